// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: writes a solid colour into a byte-per-pixel framebuffer,
// four pixels per 32-bit word, clipped to the screen, in row-major order.
module fb_rect_fill #(
  parameter int unsigned FB_W      = 320,
  parameter int unsigned FB_H      = 240,
  parameter int unsigned ADDR_BITS = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8:0]           x0,
  input  logic [7:0]           y0,
  input  logic [8:0]           w,
  input  logic [7:0]           h,
  input  logic [7:0]           color,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_wvalid,
  input  logic                 mem_wready,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb
);

  localparam logic [ADDR_BITS-1:0] WordsPerRow = ADDR_BITS'(FB_W / 4);

  typedef enum logic [1:0] {StIdle, StSetup, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [8:0]           x0_q, x0_d;
  logic [7:0]           y0_q, y0_d;
  logic [8:0]           w_q, w_d;
  logic [7:0]           h_q, h_d;
  logic [7:0]           color_q, color_d;
  logic [8:0]           x_last_q, x_last_d;
  logic [7:0]           y_last_q, y_last_d;
  logic [6:0]           wx_q, wx_d;
  logic [7:0]           y_q, y_d;
  logic [ADDR_BITS-1:0] row_base_q, row_base_d;
  logic                 wvalid_q, wvalid_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;

  // Clipped extents, only meaningful in SETUP.
  logic [9:0]           x_sum, x_end;
  logic [8:0]           y_sum, y_end;
  logic [8:0]           x_last_c;
  logic [7:0]           y_last_c;
  logic                 empty;
  logic [ADDR_BITS-1:0] base0;

  assign x_sum    = {1'b0, x0_q} + {1'b0, w_q};
  assign x_end    = (x_sum > 10'(FB_W)) ? 10'(FB_W) : x_sum;
  assign y_sum    = {1'b0, y0_q} + {1'b0, h_q};
  assign y_end    = (y_sum > 9'(FB_H)) ? 9'(FB_H) : y_sum;
  assign x_last_c = 9'(x_end - 10'd1);
  assign y_last_c = 8'(y_end - 9'd1);
  assign empty    = (w_q == 9'd0) || (h_q == 8'd0) ||
                    ({1'b0, x0_q} >= 10'(FB_W)) || ({1'b0, y0_q} >= 9'(FB_H));
  assign base0    = ADDR_BITS'(y0_q) * WordsPerRow;

  // Row-edge lane masks; a single-word row gets both.
  function automatic logic [3:0] lane_mask(logic [6:0] wx, logic [8:0] xf, logic [8:0] xl);
    logic [3:0] m;
    m = 4'hF;
    if (wx == xf[8:2]) m = m & (4'hF << xf[1:0]);
    if (wx == xl[8:2]) m = m & (4'hF >> (2'd3 - xl[1:0]));
    return m;
  endfunction

  logic                 end_row, last_beat;
  logic [6:0]           nwx;
  logic [ADDR_BITS-1:0] nbase;

  assign end_row   = (wx_q == x_last_q[8:2]);
  assign last_beat = end_row && (y_q == y_last_q);
  assign nwx       = end_row ? x0_q[8:2] : wx_q + 7'd1;
  assign nbase     = end_row ? row_base_q + WordsPerRow : row_base_q;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_last_d   = x_last_q;
    y_last_d   = y_last_q;
    wx_d       = wx_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    wvalid_d   = wvalid_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (empty) begin
          state_d = StDone;
        end else begin
          x_last_d   = x_last_c;
          y_last_d   = y_last_c;
          wx_d       = x0_q[8:2];
          y_d        = y0_q;
          row_base_d = base0;
          waddr_d    = base0 + ADDR_BITS'(x0_q[8:2]);
          wdata_d    = {4{color_q}};
          wstrb_d    = lane_mask(x0_q[8:2], x0_q, x_last_c);
          wvalid_d   = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (wvalid_q && mem_wready) begin
          if (last_beat) begin
            wvalid_d = 1'b0;
            state_d  = StDone;
          end else begin
            wx_d       = nwx;
            y_d        = end_row ? y_q + 8'd1 : y_q;
            row_base_d = nbase;
            waddr_d    = nbase + ADDR_BITS'(nwx);
            wstrb_d    = lane_mask(nwx, x0_q, x_last_q);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      wx_q       <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      wvalid_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_last_q   <= x_last_d;
      y_last_q   <= y_last_d;
      wx_q       <= wx_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      wvalid_q   <= wvalid_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign mem_wvalid = wvalid_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: a pixel-level model fills a beat scoreboard
// that a negedge monitor drains as the DUT issues writes.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [8:0]  w;
  logic [7:0]  h;
  logic [7:0]  color;
  logic        busy;
  logic        done;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [14:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  fb_rect_fill #(.FB_W(320), .FB_H(240), .ADDR_BITS(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .color      (color),
    .busy       (busy),
    .done       (done),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel-level reference: a word gets a beat if any of its four pixels lies inside the clip.
  task automatic push_model(input int px0, input int py0, input int pw, input int ph,
                            input logic [7:0] c);
    int xe, ye;
    beat_t b;
    xe = (px0 + pw > 320) ? 320 : px0 + pw;
    ye = (py0 + ph > 240) ? 240 : py0 + ph;
    for (int yy = py0; yy < ye; yy++) begin
      for (int wx = 0; wx < 80; wx++) begin
        logic [3:0] s;
        s = 4'h0;
        for (int k = 0; k < 4; k++) begin
          if ((4 * wx + k) >= px0 && (4 * wx + k) < xe) s[k] = 1'b1;
        end
        if (s != 4'h0) begin
          b.addr = 15'(yy * 80 + wx);
          b.strb = s;
          b.data = {4{c}};
          sb.push_back(b);
        end
      end
    end
  endtask

  // Every valid cycle must present the head of the scoreboard; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && mem_wvalid) begin
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check("beat_addr", 32'(mem_waddr), 32'(sb[0].addr));
        check("beat_strb", 32'(mem_wstrb), 32'(sb[0].strb));
        check("beat_data", mem_wdata, sb[0].data);
        if (mem_wready) void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input int px0, input int py0, input int pw, input int ph,
                       input logic [7:0] c);
    @(posedge clk);
    #1;
    x0 = 9'(px0); y0 = 8'(py0); w = 9'(pw); h = 8'(ph); color = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic finish_cmd(input string tag);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_all_beats"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mem_wready = 1'b1;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wvalid", 32'(mem_wvalid), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: aligned fill with full-rate ready
    push_model(0, 0, 8, 2, 8'hA5);
    issue(0, 0, 8, 2, 8'hA5);
    @(negedge clk);
    check("t1_setup_busy", 32'(busy), 32'd1);
    check("t1_setup_novalid", 32'(mem_wvalid), 32'd0);
    @(negedge clk);
    check("t1_valid_rise", 32'(mem_wvalid), 32'd1);
    wait_done("t1", 20, n);
    check("t1_done_latency", 32'(n), 32'd4);
    check("t1_valid_dropped", 32'(mem_wvalid), 32'd0);
    finish_cmd("t1");

    // 2: single word, inner lanes
    push_model(5, 3, 2, 1, 8'h11);
    issue(5, 3, 2, 1, 8'h11);
    wait_done("t2", 20, n);
    finish_cmd("t2");

    // 3: row straddling three words
    push_model(2, 0, 7, 1, 8'h22);
    issue(2, 0, 7, 1, 8'h22);
    wait_done("t3", 20, n);
    finish_cmd("t3");

    // 4: bottom-right clip
    push_model(318, 239, 10, 10, 8'h33);
    issue(318, 239, 10, 10, 8'h33);
    wait_done("t4", 20, n);
    finish_cmd("t4");

    // 5: backpressure, 5 stalled cycles then ready toggling
    mem_wready = 1'b0;
    push_model(0, 0, 8, 2, 8'hA5);
    issue(0, 0, 8, 2, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_rise", 32'(mem_wvalid), 32'd1);
    repeat (5) @(posedge clk);
    #1 mem_wready = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      #1 mem_wready = ~mem_wready;
      n++;
    end
    check("t5_done_seen", 32'(done), 32'd1);
    @(posedge clk); #1 mem_wready = 1'b1;
    @(negedge clk);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_all_beats", 32'(sb.size()), 32'd0);

    // 6a: zero width
    issue(10, 10, 0, 5, 8'h44);
    @(negedge clk);
    check("t6w_setup_nodone", 32'(done), 32'd0);
    @(negedge clk);
    check("t6w_done", 32'(done), 32'd1);
    check("t6w_novalid", 32'(mem_wvalid), 32'd0);
    finish_cmd("t6w");

    // 6b: x0 off-screen
    issue(320, 0, 4, 1, 8'h55);
    @(negedge clk);
    @(negedge clk);
    check("t6x_done", 32'(done), 32'd1);
    check("t6x_novalid", 32'(mem_wvalid), 32'd0);
    finish_cmd("t6x");

    // 6c: start pulsed during RUN is ignored
    push_model(0, 10, 40, 2, 8'h3C);
    issue(0, 10, 40, 2, 8'h3C);
    @(negedge clk);
    @(negedge clk);
    check("t6s_running", 32'(mem_wvalid), 32'd1);
    @(posedge clk);
    #1 x0 = 9'd100; y0 = 8'd50; w = 9'd3; h = 8'd1; color = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t6s", 60, n);
    finish_cmd("t6s");
    repeat (3) @(negedge clk);
    check("t6s_no_restart", 32'(busy), 32'd0);

    // 6d: asynchronous reset mid-RUN
    push_model(0, 20, 80, 3, 8'h66);
    issue(0, 20, 80, 3, 8'h66);
    repeat (5) @(posedge clk);
    #1;
    check("t6r_pre_valid", 32'(mem_wvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6r_wvalid", 32'(mem_wvalid), 32'd0);
    check("t6r_busy", 32'(busy), 32'd0);
    check("t6r_done", 32'(done), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    // 6e: fresh command after reset
    push_model(5, 3, 2, 1, 8'h77);
    issue(5, 3, 2, 1, 8'h77);
    wait_done("t6e", 20, n);
    finish_cmd("t6e");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
